// File: rtl/weight_cache_pkg.sv
// Shared types and default sizing for the weight cache.
package weight_cache_pkg;

    localparam int DEF_DATA_WIDTH = 64;   // 8 int8 weights per beat
    localparam int DEF_DEPTH      = 512;  // cache capacity in beats
    localparam int DEF_DIM_WIDTH  = 16;   // width of the matrix dimensions

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/weight_cache_if.sv
// Beat streams around the weight cache: upstream weights in, cached beats out.
interface weight_cache_if
    import weight_cache_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic                  sData_valid;
    logic                  sData_ready;
    logic [DATA_WIDTH-1:0] sData_payload;
    logic [DATA_WIDTH-1:0] mData;
    logic                  mValid;
    logic                  mReady;
    logic                  mLast;

    // Producer/consumer side: feeds weights upstream and drains the cached stream.
    modport master (
        output sData_valid, sData_payload, mReady,
        input  sData_ready, mData, mValid, mLast
    );

    // Cache side.
    modport slave (
        input  sData_valid, sData_payload, mReady,
        output sData_ready, mData, mValid, mLast
    );

endinterface

// File: rtl/weight_cache_ram.sv
// Simple dual-port beat store: one write port, one registered read port.
module weight_cache_ram #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 512
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Write port.
    // NOTE: the array itself is never reset; stale contents are unreachable because the pointers are.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; the output register holds its value whenever no read is issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/weight_cache.sv
// Weight cache: buffers one matrix of weight beats in a ring and replays them in order.
module weight_cache
    import weight_cache_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int DIM_WIDTH  = DEF_DIM_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DIM_WIDTH-1:0] Matrix_Row,
    input  logic [DIM_WIDTH-1:0] Matrix_Col,
    weight_cache_if.slave        bus,
    output logic                 busy,
    output logic                 done
);

    localparam int AW = $clog2(DEPTH);
    localparam int NW = AW + 1;          // occupancy spans 0..DEPTH
    localparam int CW = 2 * DIM_WIDTH;   // beat counters and total
    localparam logic [NW-1:0] FULL = NW'(DEPTH);

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [NW-1:0] count_q, count_d;     // beats held, including the one presented on mData
    logic [CW-1:0] in_cnt_q, in_cnt_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [CW-1:0] total_q, total_d;     // Matrix_Row * Matrix_Col/8, captured at start
    logic          mvalid_q, mvalid_d;
    logic          done_q, done_d;

    logic [CW-1:0] total_calc;
    logic          start_ok;
    logic          s_ready;
    logic          wr_en;
    logic          rd_en;
    logic          consume;
    logic          m_last;

    assign total_calc = CW'(Matrix_Row) * CW'(Matrix_Col >> 3);
    assign start_ok   = (Matrix_Row != '0) && (Matrix_Col != '0) && (total_calc != '0);

    assign s_ready = (state_q == RUN) && (count_q < FULL) && (in_cnt_q < total_q);
    assign wr_en   = bus.sData_valid && s_ready;
    assign consume = mvalid_q && bus.mReady;
    // Fetch the next beat whenever one is stored but not yet presented and the output slot frees up.
    assign rd_en   = (state_q == RUN) && (count_q != NW'(mvalid_q)) && (!mvalid_q || bus.mReady);
    assign m_last  = mvalid_q && (out_cnt_q == total_q - CW'(1));

    weight_cache_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (bus.sData_payload),
        .re    (rd_en),
        .raddr (rd_ptr_q),
        .rdata (bus.mData)
    );

    assign bus.sData_ready = s_ready;
    assign bus.mValid      = mvalid_q;
    assign bus.mLast       = m_last;
    assign busy            = (state_q != IDLE);
    assign done            = done_q;

    // Next-state logic for the FSM, ring pointers, occupancy and beat counters.
    // NOTE: every signal gets its default first so no path through this block can infer a latch.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        total_d   = total_q;
        mvalid_d  = mvalid_q;
        done_d    = 1'b0;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            in_cnt_d = in_cnt_q + CW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            mvalid_d = 1'b1;
        end else if (consume) begin
            mvalid_d = 1'b0;
        end
        if (consume) begin
            out_cnt_d = out_cnt_q + CW'(1);
        end
        case ({wr_en, consume})
            2'b10:   count_d = count_q + NW'(1);
            2'b01:   count_d = count_q - NW'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (start_ok) begin
                        state_d   = RUN;
                        total_d   = total_calc;
                        wr_ptr_d  = '0;
                        rd_ptr_d  = '0;
                        count_d   = '0;
                        in_cnt_d  = '0;
                        out_cnt_d = '0;
                        mvalid_d  = 1'b0;
                    end else begin
                        done_d = 1'b1;  // empty matrix finishes immediately
                    end
                end
            end
            RUN: begin
                if (consume && m_last) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register with asynchronous reset.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            total_q   <= '0;
            mvalid_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            total_q   <= total_d;
            mvalid_q  <= mvalid_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_weight_cache.sv
// Directed bench for weight_cache with a 16-beat ring so wrap-around is exercised quickly.
module tb_weight_cache;

    localparam int DW    = 64;
    localparam int DEPTH = 16;
    localparam int DIMW  = 16;

    logic            clk   = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic [DIMW-1:0] row   = '0;
    logic [DIMW-1:0] col   = '0;
    logic            busy;
    logic            done;

    weight_cache_if #(.DATA_WIDTH(DW)) bus ();

    weight_cache #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .DIM_WIDTH  (DIMW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .Matrix_Row (row),
        .Matrix_Col (col),
        .bus        (bus),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int         total_n = 0;
    int         bad_n   = 0;
    int         in_i    = 0;
    int         out_i   = 0;
    int         n_exp   = 0;
    logic [7:0] tag     = '0;

    // Beat i of a matrix tagged t: tag in the top byte, i+1 below it.
    function automatic logic [63:0] mk(input logic [7:0] t, input int i);
        return {t, 56'(i + 1)};
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total_n++;
        assert (obs === exp) else begin
            bad_n++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic begin_matrix(input int r, input int c, input logic [7:0] t);
        @(negedge clk);
        start = 1'b1;
        row   = DIMW'(r);
        col   = DIMW'(c);
        n_exp = r * (c / 8);
        tag   = t;
        in_i  = 0;
        out_i = 0;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("busy_after_start", busy, 1);
    endtask

    // Feed and drain until stop_at beats have been consumed; full runs also check the done pulse.
    task automatic stream(input bit rnd_v, input bit rnd_r, input int stop_at, input int budget);
        int          cyc   = 0;
        bit          stall = 1'b0;
        logic [63:0] held  = '0;
        while (out_i < stop_at && cyc < budget) begin
            @(negedge clk);
            cyc++;
            bus.sData_valid   = (in_i < n_exp) && (rnd_v ? ($urandom_range(0, 1) == 1) : 1'b1);
            bus.sData_payload = mk(tag, in_i);
            bus.mReady        = rnd_r ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (stall) begin
                check("hold_valid", bus.mValid, 1);
                check("hold_data", bus.mData, held);
            end
            if (bus.mValid) check("mlast", bus.mLast, (out_i == n_exp - 1));
            if (bus.mValid && bus.mReady) begin
                check("data", bus.mData, mk(tag, out_i));
                out_i++;
            end
            stall = bus.mValid && !bus.mReady;
            held  = bus.mData;
            if (in_i >= n_exp) check("no_extra_ready", bus.sData_ready, 0);
            if (bus.sData_valid && bus.sData_ready) in_i++;
        end
        check("beats_out", out_i, stop_at);
        if (stop_at == n_exp) begin
            @(negedge clk);
            bus.sData_valid = 1'b0;
            #1;
            check("done_pulse", done, 1);
            check("busy_in_done", busy, 1);
            @(negedge clk);
            #1;
            check("done_cleared", done, 0);
            check("busy_cleared", busy, 0);
            check("ready_idle", bus.sData_ready, 0);
        end
    endtask

    initial begin
        bus.sData_valid   = 1'b0;
        bus.sData_payload = '0;
        bus.mReady        = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", bus.sData_ready, 0);
        check("rst_mvalid", bus.mValid, 0);
        check("rst_mlast", bus.mLast, 0);
        check("rst_mdata", bus.mData, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        reset = 1'b0;

        // Basic 2x16 matrix: beats 0x01..0x04, mLast on the fourth.
        begin_matrix(2, 16, 8'h00);
        stream(1'b0, 1'b0, 4, 100);

        // Fill with the consumer stalled: exactly DEPTH beats accepted, then drain through 4 wraps.
        begin_matrix(8, 64, 8'hA5);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            bus.sData_valid   = (in_i < n_exp);
            bus.sData_payload = mk(tag, in_i);
            bus.mReady        = 1'b0;
            #1;
            if (bus.sData_valid && bus.sData_ready) in_i++;
        end
        check("fill_count", in_i, DEPTH);
        check("full_ready", bus.sData_ready, 0);
        check("full_mvalid", bus.mValid, 1);
        check("full_head", bus.mData, mk(tag, 0));
        check("full_mlast", bus.mLast, 0);
        stream(1'b0, 1'b0, 64, 500);

        // Random valid/ready toggling over 128 beats.
        begin_matrix(16, 64, 8'hC3);
        stream(1'b1, 1'b1, 128, 3000);

        // Zero dimension: done pulse next cycle, never busy, never ready.
        @(negedge clk);
        start = 1'b1;
        row   = '0;
        col   = DIMW'(64);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_ready", bus.sData_ready, 0);
        @(negedge clk);
        #1;
        check("zero_done_clr", done, 0);
        check("zero_ready2", bus.sData_ready, 0);

        // start while running is ignored: still 4 beats, mLast on the fourth.
        begin_matrix(2, 16, 8'h33);
        @(negedge clk);
        start = 1'b1;
        row   = DIMW'(1);
        col   = DIMW'(8);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("busy_after_restart", busy, 1);
        stream(1'b0, 1'b0, 4, 100);

        // Reset after 100 beats: outputs clear at once, then a fresh 1x8 matrix.
        begin_matrix(16, 64, 8'h5A);
        stream(1'b0, 1'b0, 100, 1000);
        reset = 1'b1;
        #1;
        check("midrst_ready", bus.sData_ready, 0);
        check("midrst_mvalid", bus.mValid, 0);
        check("midrst_mlast", bus.mLast, 0);
        check("midrst_mdata", bus.mData, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        @(negedge clk);
        reset           = 1'b0;
        bus.sData_valid = 1'b0;
        begin_matrix(1, 8, 8'h77);
        stream(1'b0, 1'b0, 1, 50);

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
